// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
//   Shared types and helpers for the radix-2 Booth sequential multiplier.
//   - state_t        : controller states (IDLE, RUN, DONE)
//   - booth_op_t     : per-step accumulator operation
//   - mult_int_width : internal operand width N = WIDTH + 1
//   - mult_ctr_width : step counter width, clog2(N)
//   - booth_decode   : maps {Q[0], q_1} onto the accumulator operation
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // One guard bit on top of the operand width lets unsigned operands be
    // zero-extended into a positive two's complement value, so the same
    // signed Booth datapath serves both modes with identical step counts.
    function automatic int mult_int_width(input int width);
        return width + 1;
    endfunction

    function automatic int mult_ctr_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
//   One combinational radix-2 Booth iteration: selects A-M, A+M or A from
//   {Q[0], q_1}, then arithmetically shifts {A, Q, q_1} right by one bit.
//
//   Parameters:
//     N       internal operand width (Q width); A and M are N+1 bits
//   Ports:
//     a_in    [N:0]    accumulator before the step
//     q_in    [N-1:0]  multiplier shift register before the step
//     q1_in            previous Q[0]
//     m_in    [N:0]    sign-extended multiplicand
//     a_out   [N:0]    accumulator after add/sub and shift
//     q_out   [N-1:0]  multiplier register after shift
//     q1_out           new q_1 (the bit shifted out of Q)
// -----------------------------------------------------------------------------
module booth_step
    import seq_mult_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N:0]   a_in,
    input  logic [N-1:0] q_in,
    input  logic         q1_in,
    input  logic [N:0]   m_in,
    output logic [N:0]   a_out,
    output logic [N-1:0] q_out,
    output logic         q1_out
);

    booth_op_t  op;
    logic [N:0] sum;

    assign op = booth_decode(q_in[0], q1_in);

    always_comb begin
        sum = a_in;
        case (op)
            OP_SUB:  sum = a_in - m_in;
            OP_ADD:  sum = a_in + m_in;
            default: sum = a_in;
        endcase
    end

    // Arithmetic shift of the concatenation {sum, Q, q_1}: the sign of the
    // accumulator is replicated, its LSB moves into Q, Q's LSB becomes q_1.
    assign a_out  = {sum[N], sum[N:1]};
    assign q_out  = {sum[0], q_in[N-1:1]};
    assign q1_out = q_in[0];

endmodule

// File: rtl/seq_mult_booth.sv
// -----------------------------------------------------------------------------
// seq_mult_booth
//   Parametrised sequential multiplier using radix-2 Booth recoding. Operands
//   are captured on an accepted start, one Booth step runs per clock, and the
//   full 2*WIDTH product is held on p until the next completion.
//
//   Optional feature macro: SEQ_MULT_MODE_EN
//     defined   : is_signed port present, selects signed/unsigned per operation
//     undefined : no is_signed port, operands are always two's complement
//
//   Parameters:
//     WIDTH        operand width, 4..32
//   Ports:
//     clk          clock, rising edge
//     reset        asynchronous, active-high reset
//     start        request, honoured only in IDLE or DONE
//     a [WIDTH]    multiplier operand, sampled with start
//     b [WIDTH]    multiplicand operand, sampled with start
//     is_signed    1: two's complement, 0: unsigned (SEQ_MULT_MODE_EN only)
//     busy         high while an operation is running
//     done         one-cycle completion pulse; p valid from this cycle on
//     p [2*WIDTH]  product
//
//   State table:
//     state   | meaning
//     --------+------------------------------------------------------------
//     ST_IDLE | waiting for start
//     ST_RUN  | one Booth step per clock, ctr counts down to 0
//     ST_DONE | done pulse, result on p; start here is accepted immediately
// -----------------------------------------------------------------------------
module seq_mult_booth
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_MODE_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int N  = mult_int_width(WIDTH);
    localparam int CW = mult_ctr_width(WIDTH);

    localparam logic [CW-1:0] CTR_LOAD = CW'(N - 1);

    state_t        state;
    logic [N:0]    acc;
    logic [N-1:0]  qreg;
    logic          q1;
    logic [N:0]    mreg;
    logic [CW-1:0] ctr;

    logic          signed_mode;
    logic [N-1:0]  q_load;
    logic [N:0]    m_load;

    logic [N:0]    acc_nx;
    logic [N-1:0]  qreg_nx;
    logic          q1_nx;

`ifdef SEQ_MULT_MODE_EN
    assign signed_mode = is_signed;
`else
    assign signed_mode = 1'b1;
`endif

    // Mode only affects how the operands are extended at load time, so it is
    // inherently fixed for the rest of the operation.
    assign q_load = {signed_mode & a[WIDTH-1], a};
    assign m_load = {{2{signed_mode & b[WIDTH-1]}}, b};

    booth_step #(
        .N (N)
    ) u_step (
        .a_in   (acc),
        .q_in   (qreg),
        .q1_in  (q1),
        .m_in   (mreg),
        .a_out  (acc_nx),
        .q_out  (qreg_nx),
        .q1_out (q1_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            qreg  <= '0;
            q1    <= 1'b0;
            mreg  <= '0;
            ctr   <= '0;
            p     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc   <= '0;
                        qreg  <= q_load;
                        mreg  <= m_load;
                        q1    <= 1'b0;
                        ctr   <= CTR_LOAD;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_nx;
                    qreg <= qreg_nx;
                    q1   <= q1_nx;
                    if (ctr == '0) begin
                        // Low 2*WIDTH bits of {A, Q} after the final step;
                        // Q is WIDTH+1 bits so only A[WIDTH-2:0] contributes.
                        p     <= {acc_nx[WIDTH-2:0], qreg_nx};
                        state <= ST_DONE;
                    end else begin
                        ctr <= ctr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_mult_booth.sv
module tb_seq_mult_booth;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    int vectors     = 0;
    int miscompares = 0;
    logic [2*WIDTH-1:0] last_p;

    seq_mult_booth #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SEQ_MULT_MODE_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication of the operands as numbers.
    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] av,
                                                  input logic [WIDTH-1:0] bv,
                                                  input logic sg);
        longint va, vb, prod;
        va   = sg ? longint'($signed(av)) : longint'(av);
        vb   = sg ? longint'($signed(bv)) : longint'(bv);
        prod = va * vb;
        return prod[2*WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 4 * LAT) begin
            @(posedge clk);
            #1;
            cyc++;
            check({tag, "_busy_done_overlap"}, 32'(busy & done), 32'(0));
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sg);
        a         = av;
        b         = bv;
        is_signed = sg;
        start     = 1'b1;
    endtask

    // Called #1 after an edge with the FSM in IDLE or DONE.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic sg);
        int cyc;
        logic [2*WIDTH-1:0] exp;
        exp = model(av, bv, sg);
        drive(av, bv, sg);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'(1));
        check({tag, "_done_after_accept"}, 32'(done), 32'(0));
        check({tag, "_p_held"}, 32'(p), 32'(last_p));
        wait_done(tag, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_product"}, 32'(p), 32'(exp));
        check({tag, "_busy_in_done"}, 32'(busy), 32'(0));
        last_p = exp;
    endtask

    initial begin
        int cyc;
        logic sg;
        logic [2*WIDTH-1:0] exp;

        reset     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b1;
        last_p    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_p", 32'(p), 32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'(0));

        // Directed products from the datasheet examples.
        run_op("neg3_x_5", 8'hFD, 8'h05, 1'b1);
        check("neg3_x_5_const", 32'(p), 32'(16'hFFF1));
        @(posedge clk);
        #1;
        check("done_single_cycle", 32'(done), 32'(0));
        check("p_stable_after_done", 32'(p), 32'(16'hFFF1));

        run_op("min_x_min", 8'h80, 8'h80, 1'b1);
        check("min_x_min_const", 32'(p), 32'(16'h4000));
        @(posedge clk);
        #1;
        run_op("max_x_min", 8'h7F, 8'h80, 1'b1);
        check("max_x_min_const", 32'(p), 32'(16'hC080));
        @(posedge clk);
        #1;

`ifdef SEQ_MULT_MODE_EN
        run_op("ff_x_ff_unsigned", 8'hFF, 8'hFF, 1'b0);
        check("ff_x_ff_unsigned_const", 32'(p), 32'(16'hFE01));
        @(posedge clk);
        #1;
        run_op("ff_x_ff_signed", 8'hFF, 8'hFF, 1'b1);
        check("ff_x_ff_signed_const", 32'(p), 32'(16'h0001));
        @(posedge clk);
        #1;
`endif

        // Start pulsed mid-run with different operands must be ignored.
        exp = model(8'h13, 8'hE7, 1'b1);
        drive(8'h13, 8'hE7, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive(8'h7F, 8'h7F, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        check("midrun_still_busy", 32'(busy), 32'(1));
        wait_done("midrun", cyc);
        check("midrun_latency", 32'(cyc + 4), 32'(LAT));
        check("midrun_product", 32'(p), 32'(exp));
        last_p = exp;

        // Back-to-back: start issued in the DONE cycle, no busy gap.
        run_op("b2b", 8'hC3, 8'h3C, 1'b1);
        run_op("b2b_second", 8'h05, 8'hF9, 1'b1);
        @(posedge clk);
        #1;

        // Reset four steps into a run aborts it.
        drive(8'h55, 8'hAA, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_p", 32'(p), 32'(0));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        last_p = '0;
        @(posedge clk);
        #1;
        run_op("after_abort", 8'h9B, 8'h47, 1'b1);
        @(posedge clk);
        #1;

        // Randomised operations, some issued back-to-back.
        for (int i = 0; i < 40; i++) begin
`ifdef SEQ_MULT_MODE_EN
            sg = 1'($urandom_range(0, 1));
`else
            sg = 1'b1;
`endif
            run_op("random", WIDTH'($urandom), WIDTH'($urandom), sg);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mult_booth.md
# seq_mult_booth

Parametrised sequential multiplier using radix-2 Booth recoding over `WIDTH`-bit operands, with a start/done handshake. It supersedes the fixed 8-bit, reset-loaded sequential multiplier in the arithmetic datapath. Operands are captured on a start pulse, and the block runs one Booth step per clock. The full-width product is held stable until the next completion.

## Interface
- `WIDTH`, default 8: operand width; legal range 4–32.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when the FSM is in IDLE or DONE.
- `a` in `WIDTH`: multiplier operand; sampled with `start`.
- `b` in `WIDTH`: multiplicand operand; sampled with `start`.
- `is_signed` in 1: 1 treats `a`/`b` as two's complement, 0 as unsigned. Present only with `SEQ_MULT_MODE_EN`.
- `busy` out 1: high while in RUN.
- `done` out 1: single-cycle pulse; `p` is valid from this cycle onward.
- `p` out `2*WIDTH`: product.

## Operation
- Internal width is N = `WIDTH`+1. Operands are extended to N bits:
  - signed: sign-extended;
  - unsigned: zero-extended.
- Datapath registers:
  - M: N+1 bits, extended `b`;
  - A: N+1 bits, accumulator;
  - Q: N bits, extended `a`;
  - q_1: 1 bit;
  - ctr: clog2(N) bits.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE with `start`=1:
  - load A=0, Q=ext(a), M=ext(b), q_1=0, ctr=N-1;
  - go to RUN.
- IDLE/DONE with `start`=0: go to IDLE.
- RUN step, based on {Q[0],q_1}:
  - 10: A=A-M;
  - 01: A=A+M;
  - 00/11: no add.
  - Then arithmetic right shift of {A,Q,q_1} by 1.
- RUN with ctr==0: the step completes; `p` <= low 2*`WIDTH` bits of {A,Q} after that step; go to DONE.
- RUN with ctr≠0: ctr decrements.
- `start` during RUN is ignored. No queuing, and the operands are not re-sampled.
- `p` changes only on the completion edge. It is not cleared by a new start.
- Arithmetic is exact for all operand pairs in both modes. No overflow is possible in `2*WIDTH` bits.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `p`=0, and all internal registers 0.
- Reset asserted mid-RUN aborts the operation immediately: `busy` and `done` drop and `p` becomes 0.
- Start accepted at edge k gives:
  - `busy`=1 after edge k;
  - Booth steps on edges k+1…k+N;
  - `done`=1 and `p` updated after edge k+N, for exactly one cycle.
- Latency is N = `WIDTH`+1 cycles from the accepting edge to `done`.
- `start` in the DONE cycle is accepted, giving back-to-back throughput of one result per N+1 cycles.
- `busy` and `done` are never high together.

## Configuration
- `SEQ_MULT_MODE_EN` defined:
  - the `is_signed` port exists and is sampled with `start`;
  - the mode is held for the whole operation.
- Not defined:
  - the `is_signed` port is absent and all operands are two's complement;
  - N stays `WIDTH`+1, so timing is identical in both builds.

## Structure
- Package `seq_mult_pkg` contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - a function returning the internal width N;
  - a function returning the counter width.
- One sub-module, `booth_step`: combinational add/sub/none selection plus the arithmetic shift on {A,Q,q_1}, parameterised by N.
- The FSM, counter and registers stay in `seq_mult_booth`.

## Test plan
- `WIDTH`=8, signed, a=-3, b=5 → `done` 9 cycles after start, `p`=16'hFFF1.
- Signed a=-128, b=-128 → `p`=16'h4000. Signed a=127, b=-128 → `p`=16'hC080.
- With `SEQ_MULT_MODE_EN`, `is_signed`=0, a=8'hFF, b=8'hFF → `p`=16'hFE01. The same operands with `is_signed`=1 → `p`=16'h0001.
- `start` pulsed mid-RUN with new operands → ignored; the original product is delivered on schedule.
- Second `start` in the DONE cycle → second `done` exactly 9 cycles later, correct product, and no `busy` gap beyond DONE.
- `reset` asserted at step 4 → outputs 0 immediately; a subsequent start produces a correct result.
